mdu_ctrl: RTL and testbench

//  Multiply/divide unit controller for the 5-stage MIPS pipeline. Accepts MDU ops from the E stage and

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_if.sv | 24 ++
 rtl/mdu_calc.sv | 100 ++++++++++
 rtl/mdu_ctrl.sv | 92 +++++++++
 tb/tb_mdu_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// counter width and arithmetic constants.
package mdu_pkg;

  localparam int unsigned MDU_CNT_W = 4;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

  // Divides use the long busy window; every other sequenced op uses the multiply window.
  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> MDU signal bundle. master = pipeline side, slave = MDU side.
interface mdu_if;

  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_use_md;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output md_start, md_op, rs_val, rt_val, d_use_md,
    input  busy, stall_req, hi_out, lo_out
  );

  modport slave (
    input  md_start, md_op, rs_val, rt_val, d_use_md,
    output busy, stall_req, hi_out, lo_out
  );

endinterface

// File: rtl/mdu_calc.sv
// Combinational result generator for MULT/MULTU/DIV/DIVU (and MADD/MADDU/
// MSUB/MSUBU when MDU_MADD_EN is defined). o_valid marks ops that run a busy
// window and commit o_hi_res/o_lo_res. A zero divisor yields the incoming
// HI/LO so the commit leaves them unchanged.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_hi_res,
  output logic [31:0] o_lo_res,
  output logic        o_valid
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div0;
  logic        w_ovf;
  logic [31:0] w_sdiv;
  logic [31:0] w_udiv;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
  assign w_prod_u = {32'b0, i_rs} * {32'b0, i_rt};

  assign w_div0 = (i_rt == '0);
  assign w_ovf  = (i_rs == INT_MIN) && (i_rt == '1);

  // INT_MIN / -1 is replaced by INT_MIN / 1, which gives exactly the required
  // LO=INT_MIN, HI=0; a zero divisor is also replaced so the divider never sees 0.
  assign w_sdiv = (w_div0 || w_ovf) ? 32'd1 : i_rt;
  assign w_udiv = w_div0 ? 32'd1 : i_rt;

  assign w_sq = $signed(i_rs) / $signed(w_sdiv);
  assign w_sr = $signed(i_rs) % $signed(w_sdiv);
  assign w_uq = i_rs / w_udiv;
  assign w_ur = i_rs % w_udiv;

`ifdef MDU_MADD_EN
  logic [63:0] w_hilo;
  assign w_hilo = {i_hi, i_lo};
`endif

  // Select the result for the current op; non-sequenced ops pass HI/LO through.
  always_comb begin
    o_hi_res = i_hi;
    o_lo_res = i_lo;
    o_valid  = 1'b0;
    case (i_op)
      OP_MULT: begin
        {o_hi_res, o_lo_res} = w_prod_s;
        o_valid = 1'b1;
      end
      OP_MULTU: begin
        {o_hi_res, o_lo_res} = w_prod_u;
        o_valid = 1'b1;
      end
      OP_DIV: begin
        o_valid = 1'b1;
        if (!w_div0) begin
          o_lo_res = w_sq;
          o_hi_res = w_sr;
        end
      end
      OP_DIVU: begin
        o_valid = 1'b1;
        if (!w_div0) begin
          o_lo_res = w_uq;
          o_hi_res = w_ur;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        {o_hi_res, o_lo_res} = w_hilo + w_prod_s;
        o_valid = 1'b1;
      end
      OP_MADDU: begin
        {o_hi_res, o_lo_res} = w_hilo + w_prod_u;
        o_valid = 1'b1;
      end
      OP_MSUB: begin
        {o_hi_res, o_lo_res} = w_hilo - w_prod_s;
        o_valid = 1'b1;
      end
      OP_MSUBU: begin
        {o_hi_res, o_lo_res} = w_hilo - w_prod_u;
        o_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: sequences the multi-cycle busy window,
// owns HI/LO and raises the D-stage stall request. Results are computed at
// start, held in pending registers and committed on the last busy cycle, so
// HI/LO never show a partial value.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam logic [MDU_CNT_W-1:0] MULT_N  = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_N   = MDU_CNT_W'(DIV_CYCLES);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE = MDU_CNT_W'(1);

  mdu_state_e           r_state;
  logic [MDU_CNT_W-1:0] r_cnt;
  logic                 r_busy;
  logic [31:0]          r_hi;
  logic [31:0]          r_lo;
  logic [31:0]          r_hi_pend;
  logic [31:0]          r_lo_pend;

  logic [31:0]          w_hi_res;
  logic [31:0]          w_lo_res;
  logic                 w_valid;

  mdu_calc u_calc (
    .i_op     (bus.md_op),
    .i_rs     (bus.rs_val),
    .i_rt     (bus.rt_val),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_hi_res (w_hi_res),
    .o_lo_res (w_lo_res),
    .o_valid  (w_valid)
  );

  // FSM: accept ops in IDLE, count down the busy window in RUN, commit on the last cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_hi_pend <= '0;
      r_lo_pend <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.md_start) begin
            if (w_valid) begin
              r_hi_pend <= w_hi_res;
              r_lo_pend <= w_lo_res;
              r_cnt     <= op_is_div(bus.md_op) ? DIV_N : MULT_N;
              r_busy    <= 1'b1;
              r_state   <= ST_RUN;
            end else if (bus.md_op == OP_MTHI) begin
              r_hi <= bus.rs_val;
            end else if (bus.md_op == OP_MTLO) begin
              r_lo <= bus.rs_val;
            end
          end
        end
        ST_RUN: begin
          if (r_cnt == CNT_ONE) begin
            r_hi    <= r_hi_pend;
            r_lo    <= r_lo_pend;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.hi_out    = r_hi;
  assign bus.lo_out    = r_lo;
  assign bus.stall_req = bus.d_use_md & (r_busy | (bus.md_start & w_valid));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a deadline-based behavioural model checked
// every cycle, plus directed vectors with hand-computed HI/LO/busy-length values.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdu_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_seq(input logic [3:0] op);
    bit r;
    r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] rs,
                                               input logic [31:0] rt, input logic [31:0] hi,
                                               input logic [31:0] lo);
    int     si_a, si_b;
    longint sa, sb, ua, ub, q, r;
    logic [63:0] acc;
    si_a = rs; si_b = rt;
    sa = si_a; sb = si_b;
    ua = {32'b0, rs}; ub = {32'b0, rt};
    acc = {hi, lo};
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return 64'(ua * ub);
      OP_DIV: begin
        if (rt == 32'd0) return acc;
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (rt == 32'd0) return acc;
        q = ua / ub; r = ua % ub;
        return {r[31:0], q[31:0]};
      end
      OP_MADD:  return acc + 64'(sa * sb);
      OP_MADDU: return acc + 64'(ua * ub);
      OP_MSUB:  return acc - 64'(sa * sb);
      OP_MSUBU: return acc - 64'(ua * ub);
      default:  return acc;
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  bit          m_run = 1'b0;
  longint      m_cyc = 0, m_due = 0;

  // Model: an op started at edge c commits at edge c+N; inputs are ignored until then.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi  <= '0;
      m_lo  <= '0;
      m_run <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_run) begin
        if (m_cyc + 1 == m_due) begin
          m_hi  <= m_phi;
          m_lo  <= m_plo;
          m_run <= 1'b0;
        end
      end else if (bus.md_start) begin
        if (is_seq(bus.md_op)) begin
          {m_phi, m_plo} <= model_result(bus.md_op, bus.rs_val, bus.rt_val, m_hi, m_lo);
          m_due <= m_cyc + 1 + ((bus.md_op == OP_DIV || bus.md_op == OP_DIVU) ? 10 : 5);
          m_run <= 1'b1;
        end else if (bus.md_op == OP_MTHI) begin
          m_hi <= bus.rs_val;
        end else if (bus.md_op == OP_MTLO) begin
          m_lo <= bus.rs_val;
        end
      end
    end
  end

  // Compare DUT against the model once per cycle, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model busy", 32'(bus.busy), 32'(m_run));
      check("model stall", 32'(bus.stall_req),
            32'(bus.d_use_md & (m_run | (bus.md_start & is_seq(bus.md_op)))));
      check("model hi", bus.hi_out, m_hi);
      check("model lo", bus.lo_out, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic d_use);
    bus.md_start = 1'b1;
    bus.md_op    = op;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    bus.d_use_md = d_use;
    step();
    bus.md_start = 1'b0;
  endtask

  // Issue one op, measure the busy length, then check final HI/LO.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    drive(op, rs, rt, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    check({name, " busy_len"}, 32'(n), 32'(exp_n));
    check({name, " hi"}, bus.hi_out, exp_hi);
    check({name, " lo"}, bus.lo_out, exp_lo);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.md_start = 1'b0;
    bus.md_op    = '0;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
    bus.d_use_md = 1'b0;
    reset        = 1'b0;
    chk_en       = 1'b1;

    // 1. Reset state
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst stall", 32'(bus.stall_req), 32'd0);
      check("rst hi", bus.hi_out, 32'd0);
      check("rst lo", bus.lo_out, 32'd0);
    end
    step();
    reset = 1'b1;
    step();

    // Reset mid-RUN: nonzero HI first, then abort a MULT three cycles in
    run_op("mthi_a", OP_MTHI, 32'h0000_AAAA, 32'd0, 0, 32'h0000_AAAA, 32'd0);
    drive(OP_MULT, 32'd6, 32'd7, 1'b0);
    step(); step(); step();
    reset = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort hi", bus.hi_out, 32'd0);
    check("abort lo", bus.lo_out, 32'd0);
    step(); step();
    reset = 1'b1;
    repeat (8) step();
    check("abort nocommit hi", bus.hi_out, 32'd0);
    check("abort nocommit lo", bus.lo_out, 32'd0);

    // 2. Multiplies
    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);

    // 3. Divides
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", OP_DIVU, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 10, 32'h0000_000F, 32'h0FFF_FFFF);
    run_op("divneg", OP_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);

    // 4. Stall contract with a D-stage MDU user
    bus.md_start = 1'b1;
    bus.md_op    = OP_MULTU;
    bus.rs_val   = 32'h0001_0000;
    bus.rt_val   = 32'h0001_0000;
    bus.d_use_md = 1'b1;
    @(negedge clk);
    check("stall start", 32'(bus.stall_req), 32'd1);
    step();
    bus.md_start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      check("stall busy", 32'(bus.stall_req), 32'd1);
    end
    check("stall busy_len", 32'(n), 32'd5);
    check("stall after", 32'(bus.stall_req), 32'd0);
    check("mfhi", bus.hi_out, 32'h0000_0001);
    check("mflo", bus.lo_out, 32'h0000_0000);
    step();
    bus.d_use_md = 1'b0;

    // 5. MTHI/MTLO, and a start dropped while running
    run_op("mthi", OP_MTHI, 32'h0000_1234, 32'd0, 0, 32'h0000_1234, 32'd0);
    run_op("mtlo", OP_MTLO, 32'h0000_5678, 32'd0, 0, 32'h0000_1234, 32'h0000_5678);
    drive(OP_MULT, 32'd6, 32'd7, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.md_start = 1'b1;
        bus.md_op    = OP_DIV;
        bus.rs_val   = 32'd100;
        bus.rt_val   = 32'd3;
      end else begin
        bus.md_start = 1'b0;
      end
      if (!bus.busy) break;
      n++;
    end
    bus.md_start = 1'b0;
    check("drop busy_len", 32'(n), 32'd5);
    check("drop hi", bus.hi_out, 32'd0);
    check("drop lo", bus.lo_out, 32'd42);
    step();
    run_op("badop", 4'hF, 32'hDEAD_BEEF, 32'd1, 0, 32'd0, 32'd42);

    // 6. Multiply-accumulate
    run_op("mthi0", OP_MTHI, 32'd0, 32'd0, 0, 32'd0, 32'd42);
    run_op("mtlo1", OP_MTLO, 32'hFFFF_FFFF, 32'd0, 0, 32'd0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5, 32'h0000_0001, 32'h0000_0000);
    run_op("msub", OP_MSUB, 32'd2, 32'd3, 5, 32'h0000_0000, 32'hFFFF_FFFA);
`else
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, 0, 32'h0000_0000, 32'hFFFF_FFFF);
    bus.md_start = 1'b1;
    bus.md_op    = OP_MSUB;
    bus.d_use_md = 1'b1;
    @(negedge clk);
    check("msub nostall", 32'(bus.stall_req), 32'd0);
    step();
    bus.md_start = 1'b0;
    bus.d_use_md = 1'b0;
    @(negedge clk);
    check("msub nobusy", 32'(bus.busy), 32'd0);
    step();
`endif

    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
